alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined ALU with valid/ready handshakes. Stage 1
//               registers preprocessed adder operands; stage 2 forms the
//               result and Z/N/C/V flags. Optional macro ALU_PIPE_SAT_EN
//               clamps signed overflow on NEG/ADD/INC/SUB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] c_op_pass = 3'b000;
    localparam logic [2:0] c_op_neg  = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_inc  = 3'b011;
    localparam logic [2:0] c_op_sub  = 3'b100;
    localparam logic [2:0] c_op_and  = 3'b101;
    localparam logic [2:0] c_op_or   = 3'b110;

    localparam logic [1:0] c_lsel_arith = 2'b00;
    localparam logic [1:0] c_lsel_and   = 2'b01;
    localparam logic [1:0] c_lsel_or    = 2'b10;
    localparam logic [1:0] c_lsel_xor   = 2'b11;

    // Stage 1 state
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_amod;
    logic [WIDTH-1:0] r_s1_bmod;
    logic             r_s1_cin;
    logic [1:0]       r_s1_lsel;
    logic             r_s1_ovf_en;

    // Stage 2 state
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic             r_v;

    // Operand preprocessing
    logic [WIDTH-1:0] w_amod;
    logic [WIDTH-1:0] w_bmod;
    logic             w_cin;
    logic [1:0]       w_lsel;
    logic             w_ovf_en;

    // Stage 2 datapath
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_arith;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    // Handshake control
    logic             w_s2_load;
    logic             w_s1_load;

    // Stage 2 accepts new data when empty or when its result is being taken;
    // stage 1 drains into stage 2 on exactly the same condition.
    assign w_s2_load = ~r_s2_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_s1_load = in_valid & in_ready;

    always_comb begin
        w_amod   = A;
        w_bmod   = B;
        w_cin    = 1'b0;
        w_lsel   = c_lsel_arith;
        w_ovf_en = 1'b0;
        case (Op)
            c_op_pass: begin
                w_amod = '0;
                w_bmod = A;
            end
            c_op_neg: begin
                w_amod   = '0;
                w_bmod   = ~A;
                w_cin    = 1'b1;
                w_ovf_en = 1'b1;
            end
            c_op_add: begin
                w_ovf_en = 1'b1;
            end
            c_op_inc: begin
                w_bmod   = '0;
                w_cin    = 1'b1;
                w_ovf_en = 1'b1;
            end
            c_op_sub: begin
                w_bmod   = ~B;
                w_cin    = 1'b1;
                w_ovf_en = 1'b1;
            end
            c_op_and: w_lsel = c_lsel_and;
            c_op_or:  w_lsel = c_lsel_or;
            default:  w_lsel = c_lsel_xor;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_amod   <= '0;
            r_s1_bmod   <= '0;
            r_s1_cin    <= 1'b0;
            r_s1_lsel   <= c_lsel_arith;
            r_s1_ovf_en <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_s1_load) begin
                r_s1_amod   <= w_amod;
                r_s1_bmod   <= w_bmod;
                r_s1_cin    <= w_cin;
                r_s1_lsel   <= w_lsel;
                r_s1_ovf_en <= w_ovf_en;
            end
        end
    end

    assign w_sum   = {1'b0, r_s1_amod} + {1'b0, r_s1_bmod} + {{WIDTH{1'b0}}, r_s1_cin};
    assign w_carry = w_sum[WIDTH];
    // Overflow when both adder inputs share a sign the sum does not.
    assign w_ovf   = r_s1_ovf_en & (r_s1_amod[WIDTH-1] == r_s1_bmod[WIDTH-1])
                                 & (w_sum[WIDTH-1] != r_s1_amod[WIDTH-1]);

`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

    // The overflow direction follows the common sign of the adder inputs.
    assign w_arith = w_ovf ? (r_s1_amod[WIDTH-1] ? c_smin : c_smax) : w_sum[WIDTH-1:0];
`else
    assign w_arith = w_sum[WIDTH-1:0];
`endif

    always_comb begin
        w_res = w_arith;
        w_c   = w_carry;
        w_v   = w_ovf;
        case (r_s1_lsel)
            c_lsel_and: begin
                w_res = r_s1_amod & r_s1_bmod;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            c_lsel_or: begin
                w_res = r_s1_amod | r_s1_bmod;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            c_lsel_xor: begin
                w_res = r_s1_amod ^ r_s1_bmod;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_z      <= (w_res == '0);
                r_n      <= w_res[WIDTH-1];
                r_c      <= w_c;
                r_v      <= w_v;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign R         = r_result;
    assign Z         = r_z;
    assign N         = r_n;
    assign C         = r_c;
    assign V         = r_v;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for alu_pipe (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] R;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;
    logic             out_valid;
    logic             out_ready;

    int checks;
    int errors;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .R         (R),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op into an empty pipe and capture {R,Z,N,C,V} one edge after acceptance.
    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] res, output logic ov);
        @(posedge clk); #1;
        A = a; B = b; Op = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        res = {R, Z, N, C, V};
        ov  = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Op = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if ({R, Z, N, C, V} !== 8'h00) begin
            errors++; $display("FAIL reset_result_flags: got %h want 00", {R, Z, N, C, V});
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_arith();
        logic [2:0] t_op  [12];
        logic [3:0] t_a   [12];
        logic [3:0] t_b   [12];
        logic [7:0] t_exp [12];
        logic [7:0] res;
        logic       ov;
        // Expected packed as {R, Z, N, C, V}
        t_op[0]  = 3'b010; t_a[0]  = 4'd7;  t_b[0]  = 4'd1;
        t_op[1]  = 3'b100; t_a[1]  = 4'd3;  t_b[1]  = 4'd5;  t_exp[1]  = {4'd14, 4'b0100};
        t_op[2]  = 3'b100; t_a[2]  = 4'd5;  t_b[2]  = 4'd3;  t_exp[2]  = {4'd2,  4'b0010};
        t_op[3]  = 3'b001; t_a[3]  = 4'd0;  t_b[3]  = 4'd0;  t_exp[3]  = {4'd0,  4'b1010};
        t_op[4]  = 3'b001; t_a[4]  = 4'd8;  t_b[4]  = 4'd0;
        t_op[5]  = 3'b000; t_a[5]  = 4'd9;  t_b[5]  = 4'd3;  t_exp[5]  = {4'd9,  4'b0100};
        t_op[6]  = 3'b011; t_a[6]  = 4'd7;  t_b[6]  = 4'd5;
        t_op[7]  = 3'b101; t_a[7]  = 4'd12; t_b[7]  = 4'd10; t_exp[7]  = {4'd8,  4'b0100};
        t_op[8]  = 3'b110; t_a[8]  = 4'd5;  t_b[8]  = 4'd2;  t_exp[8]  = {4'd7,  4'b0000};
        t_op[9]  = 3'b111; t_a[9]  = 4'd6;  t_b[9]  = 4'd6;  t_exp[9]  = {4'd0,  4'b1000};
        t_op[10] = 3'b100; t_a[10] = 4'd8;  t_b[10] = 4'd1;
        t_op[11] = 3'b010; t_a[11] = 4'd9;  t_b[11] = 4'd7;  t_exp[11] = {4'd0,  4'b1010};
`ifdef ALU_PIPE_SAT_EN
        t_exp[0]  = {4'd7, 4'b0001};
        t_exp[4]  = {4'd7, 4'b0001};
        t_exp[6]  = {4'd7, 4'b0001};
        t_exp[10] = {4'd8, 4'b0111};
`else
        t_exp[0]  = {4'd8, 4'b0101};
        t_exp[4]  = {4'd8, 4'b0101};
        t_exp[6]  = {4'd8, 4'b0101};
        t_exp[10] = {4'd7, 4'b0011};
`endif
        for (int i = 0; i < 12; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, ov);
            checks++;
            if ({ov, res} !== {1'b1, t_exp[i]}) begin
                errors++;
                $display("FAIL arith_vec%0d op=%b a=%0d b=%0d: got valid=%b RZNCV=%h want valid=1 RZNCV=%h",
                         i, t_op[i], t_a[i], t_b[i], ov, res, t_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(posedge clk); #1;
        A = 4'd1; B = 4'd1; Op = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_first_latency: got out_valid=%b want 0", out_valid);
        end
        A = 4'd5; B = 4'd3; Op = 3'b111;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, R, Z, N, C, V} !== {1'b1, 4'd2, 4'b0000}) begin
            errors++; $display("FAIL b2b_add: got %b want %b", {out_valid, R, Z, N, C, V}, {1'b1, 4'd2, 4'b0000});
        end
        A = 4'd15; B = 4'd0; Op = 3'b011;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, R, Z, N, C, V} !== {1'b1, 4'd6, 4'b0000}) begin
            errors++; $display("FAIL b2b_xor: got %b want %b", {out_valid, R, Z, N, C, V}, {1'b1, 4'd6, 4'b0000});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, R, Z, N, C, V} !== {1'b1, 4'd0, 4'b1010}) begin
            errors++; $display("FAIL b2b_inc: got %b want %b", {out_valid, R, Z, N, C, V}, {1'b1, 4'd0, 4'b1010});
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] p_op  [4];
        logic [3:0] p_a   [4];
        logic [3:0] p_b   [4];
        logic [3:0] p_exp [4];
        logic [3:0] got   [$];
        int         idx;
        int         stable_bad;
        logic       acc_pending;
        p_op[0] = 3'b010; p_a[0] = 4'd2;  p_b[0] = 4'd3; p_exp[0] = 4'd5;
        p_op[1] = 3'b110; p_a[1] = 4'd8;  p_b[1] = 4'd1; p_exp[1] = 4'd9;
        p_op[2] = 3'b111; p_a[2] = 4'd15; p_b[2] = 4'd4; p_exp[2] = 4'd11;
        p_op[3] = 3'b000; p_a[3] = 4'd6;  p_b[3] = 4'd2; p_exp[3] = 4'd6;
        idx = 0; stable_bad = 0; acc_pending = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clk); #1;
            if (acc_pending) idx++;
            out_ready = (cyc >= 6);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                A = p_a[idx]; B = p_b[idx]; Op = p_op[idx];
            end
            #1;
            acc_pending = in_valid & in_ready;
            if (out_valid && !out_ready && R !== p_exp[0]) stable_bad++;
            if (out_valid && out_ready) got.push_back(R);
            if (cyc == 5) begin
                checks++;
                if ({idx[2:0], in_ready, out_valid} !== {3'd2, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL bp_stall: got accepted=%0d in_ready=%b out_valid=%b want accepted=2 in_ready=0 out_valid=1",
                             idx, in_ready, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (stable_bad != 0) begin
            errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles want 0", stable_bad);
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d results want 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== p_exp[i]) begin
                errors++;
                $display("FAIL bp_order%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 4'hx, p_exp[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        out_ready = 1'b0;
        @(posedge clk); #1;
        A = 4'd3; B = 4'd4; Op = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 4'd1; B = 4'd2; Op = 3'b010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, R} !== {1'b1, 1'b0, 4'd7}) begin
            errors++; $display("FAIL rst_fill: got %b want %b", {out_valid, in_ready, R}, {1'b1, 1'b0, 4'd7});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, R, Z, N, C, V} !== 9'd0) begin
            errors++; $display("FAIL rst_async_clear: got %b want 0", {out_valid, R, Z, N, C, V});
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, R} !== 5'd0) begin
            errors++; $display("FAIL rst_held: got %b want 0", {out_valid, R});
        end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL rst_no_stale: got %0d valid cycles want 0", stale);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
